// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared definitions for the hardwired control sequencer:
//                opcodes, ALU function codes, state encodings and the
//                instruction-class decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Instruction opcodes (ir[31:27])
    localparam logic [4:0] c_OP_ADD  = 5'b00011;
    localparam logic [4:0] c_OP_SUB  = 5'b00100;
    localparam logic [4:0] c_OP_AND  = 5'b00101;
    localparam logic [4:0] c_OP_OR   = 5'b00110;
    localparam logic [4:0] c_OP_SHR  = 5'b00111;
    localparam logic [4:0] c_OP_SHL  = 5'b01001;
    localparam logic [4:0] c_OP_ROR  = 5'b01010;
    localparam logic [4:0] c_OP_ROL  = 5'b01011;
    localparam logic [4:0] c_OP_MUL  = 5'b01111;
    localparam logic [4:0] c_OP_DIV  = 5'b10000;
    localparam logic [4:0] c_OP_NEG  = 5'b10001;
    localparam logic [4:0] c_OP_NOT  = 5'b10010;
    localparam logic [4:0] c_OP_NOP  = 5'b11010;
    localparam logic [4:0] c_OP_HALT = 5'b11011;

    // ALU function select codes driven on alu_op
    localparam logic [3:0] c_ALU_ADD = 4'd0;
    localparam logic [3:0] c_ALU_SUB = 4'd1;
    localparam logic [3:0] c_ALU_AND = 4'd2;
    localparam logic [3:0] c_ALU_OR  = 4'd3;
    localparam logic [3:0] c_ALU_SHR = 4'd4;
    localparam logic [3:0] c_ALU_SHL = 4'd5;
    localparam logic [3:0] c_ALU_ROR = 4'd6;
    localparam logic [3:0] c_ALU_ROL = 4'd7;
    localparam logic [3:0] c_ALU_MUL = 4'd8;
    localparam logic [3:0] c_ALU_DIV = 4'd9;
    localparam logic [3:0] c_ALU_NEG = 4'd10;
    localparam logic [3:0] c_ALU_NOT = 4'd11;
    localparam logic [3:0] c_ALU_INC = 4'd12;

    // State encodings, visible on state_o
    localparam logic [3:0] c_ST_RST  = 4'd0;
    localparam logic [3:0] c_ST_T0   = 4'd1;
    localparam logic [3:0] c_ST_T1   = 4'd2;
    localparam logic [3:0] c_ST_T2   = 4'd3;
    localparam logic [3:0] c_ST_T3   = 4'd4;
    localparam logic [3:0] c_ST_T4   = 4'd5;
    localparam logic [3:0] c_ST_T5   = 4'd6;
    localparam logic [3:0] c_ST_T6   = 4'd7;
    localparam logic [3:0] c_ST_HALT = 4'd8;

    typedef enum logic [3:0] {
        S_RST  = c_ST_RST,
        S_T0   = c_ST_T0,
        S_T1   = c_ST_T1,
        S_T2   = c_ST_T2,
        S_T3   = c_ST_T3,
        S_T4   = c_ST_T4,
        S_T5   = c_ST_T5,
        S_T6   = c_ST_T6,
        S_HALT = c_ST_HALT
    } state_t;

    // Execute-phase behaviour groups
    typedef enum logic [2:0] {
        CL_NOP    = 3'd0,
        CL_ALU3   = 3'd1,
        CL_MULDIV = 3'd2,
        CL_UNARY  = 3'd3,
        CL_HALT   = 3'd4
    } iclass_t;

    // Unknown opcodes fall into CL_NOP so they retire harmlessly
    function automatic iclass_t op_class(input logic [4:0] op);
        case (op)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
            c_OP_SHR, c_OP_SHL, c_OP_ROR, c_OP_ROL: op_class = CL_ALU3;
            c_OP_MUL, c_OP_DIV:                     op_class = CL_MULDIV;
            c_OP_NEG, c_OP_NOT:                     op_class = CL_UNARY;
            c_OP_HALT:                              op_class = CL_HALT;
            default:                                op_class = CL_NOP;
        endcase
    endfunction

    function automatic logic [3:0] op_alu(input logic [4:0] op);
        case (op)
            c_OP_SUB: op_alu = c_ALU_SUB;
            c_OP_AND: op_alu = c_ALU_AND;
            c_OP_OR:  op_alu = c_ALU_OR;
            c_OP_SHR: op_alu = c_ALU_SHR;
            c_OP_SHL: op_alu = c_ALU_SHL;
            c_OP_ROR: op_alu = c_ALU_ROR;
            c_OP_ROL: op_alu = c_ALU_ROL;
            c_OP_MUL: op_alu = c_ALU_MUL;
            c_OP_DIV: op_alu = c_ALU_DIV;
            c_OP_NEG: op_alu = c_ALU_NEG;
            c_OP_NOT: op_alu = c_ALU_NOT;
            default:  op_alu = c_ALU_ADD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_sequencer_reg_sel_dec.sv
`default_nettype none
// ============================================================================
//  Module      : reg_sel_dec
//  Description : 4-bit register field to one-hot enable vector, gated by an
//                enable so the whole vector is zero when no register is used.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_sel_dec #(
    parameter int NREG = 16
) (
    input  logic [3:0]      i_sel,
    input  logic            i_en,
    output logic [NREG-1:0] o_onehot
);

    // One comparator per register; at most one can match a given field value
    for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
        localparam logic [3:0] c_IDX = 4'(gi);
        assign o_onehot[gi] = i_en && (i_sel == c_IDX);
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_sequencer
//  Description : Hardwired control unit. Runs a three-state fetch, decodes
//                IR and sequences the execute states for register ALU,
//                mul/div, unary, nop and halt instructions. All strobes are
//                Moore outputs of the state register and the IR contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_sequencer #(
    parameter int NREG    = 16,
    parameter int ALU_OPW = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [31:0]        ir,
    input  logic               mem_rdy,
    output logic               PCout,
    output logic               MARin,
    output logic               IncPC,
    output logic               Zin,
    output logic               Zlowout,
    output logic               Zhighout,
    output logic               PCin,
    output logic               Read,
    output logic               MDRin,
    output logic               MDRout,
    output logic               IRin,
    output logic               Yin,
    output logic               HIin,
    output logic               LOin,
    output logic [NREG-1:0]    rin,
    output logic [NREG-1:0]    rout,
    output logic [ALU_OPW-1:0] alu_op,
    output logic               run,
    output logic [3:0]         state_o
);

    import ctrl_pkg::*;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] w_opcode;
    logic [3:0] w_ra;
    logic [3:0] w_rb;
    logic [3:0] w_rc;
    iclass_t    w_class;
    logic [3:0] w_aop_ex;
    logic [3:0] w_aop;
    logic       w_rin_en;
    logic       w_rout_en;
    logic [3:0] w_rin_sel;
    logic [3:0] w_rout_sel;
    logic       w_unused_ir;

    assign w_opcode    = ir[31:27];
    assign w_ra        = ir[26:23];
    assign w_rb        = ir[22:19];
    assign w_rc        = ir[18:15];
    assign w_unused_ir = ^ir[14:0];
    assign w_class     = op_class(w_opcode);
    assign w_aop_ex    = op_alu(w_opcode);

    // State register; clr forces RST immediately, independent of the clock
    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= S_RST;
        else     r_state <= w_next;
    end

    // Next-state and strobe decode; mem_rdy only steers the T1 transition
    always_comb begin
        w_next     = r_state;
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        PCin       = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        w_aop      = 4'd0;
        w_rin_en   = 1'b0;
        w_rin_sel  = 4'd0;
        w_rout_en  = 1'b0;
        w_rout_sel = 4'd0;
        run        = 1'b1;
        case (r_state)
            S_RST: w_next = S_T0;
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zin    = 1'b1;
                w_aop  = c_ALU_INC;
                w_next = S_T1;
            end
            S_T1: begin
                // Reloading PC from an unchanged Z while waiting is harmless
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_rdy) w_next = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                w_next = S_T3;
            end
            S_T3: begin
                case (w_class)
                    CL_ALU3: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_rb;
                        Yin        = 1'b1;
                        w_next     = S_T4;
                    end
                    CL_MULDIV: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_ra;
                        Yin        = 1'b1;
                        w_next     = S_T4;
                    end
                    CL_UNARY: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_rb;
                        Zin        = 1'b1;
                        w_aop      = w_aop_ex;
                        w_next     = S_T4;
                    end
                    CL_HALT: w_next = S_HALT;
                    default: w_next = S_T0;
                endcase
            end
            S_T4: begin
                case (w_class)
                    CL_ALU3: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_rc;
                        Zin        = 1'b1;
                        w_aop      = w_aop_ex;
                        w_next     = S_T5;
                    end
                    CL_MULDIV: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_rb;
                        Zin        = 1'b1;
                        w_aop      = w_aop_ex;
                        w_next     = S_T5;
                    end
                    CL_UNARY: begin
                        Zlowout   = 1'b1;
                        w_rin_en  = 1'b1;
                        w_rin_sel = w_ra;
                        w_next    = S_T0;
                    end
                    default: w_next = S_T0;
                endcase
            end
            S_T5: begin
                case (w_class)
                    CL_ALU3: begin
                        Zlowout   = 1'b1;
                        w_rin_en  = 1'b1;
                        w_rin_sel = w_ra;
                        w_next    = S_T0;
                    end
                    CL_MULDIV: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                        w_next  = S_T6;
                    end
                    default: w_next = S_T0;
                endcase
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                w_next   = S_T0;
            end
            S_HALT: begin
                run    = 1'b0;
                w_next = S_HALT;
            end
            default: w_next = S_RST;
        endcase
    end

    reg_sel_dec #(.NREG(NREG)) u_rin_dec (
        .i_sel    (w_rin_sel),
        .i_en     (w_rin_en),
        .o_onehot (rin)
    );

    reg_sel_dec #(.NREG(NREG)) u_rout_dec (
        .i_sel    (w_rout_sel),
        .i_en     (w_rout_en),
        .o_onehot (rout)
    );

    assign alu_op  = ALU_OPW'(w_aop);
    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_sequencer
//  Description : Self-checking bench for ctrl_sequencer. Each instruction is
//                expanded into a per-cycle list of expected outputs, then
//                the DUT is stepped and compared cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_sequencer;

    import ctrl_pkg::*;

    localparam int NREG    = 16;
    localparam int ALU_OPW = 4;

    // Strobe bit positions in the packed strobe vector
    localparam logic [13:0] SB_PCOUT  = 14'h2000;
    localparam logic [13:0] SB_MARIN  = 14'h1000;
    localparam logic [13:0] SB_INCPC  = 14'h0800;
    localparam logic [13:0] SB_ZIN    = 14'h0400;
    localparam logic [13:0] SB_ZLOW   = 14'h0200;
    localparam logic [13:0] SB_ZHIGH  = 14'h0100;
    localparam logic [13:0] SB_PCIN   = 14'h0080;
    localparam logic [13:0] SB_READ   = 14'h0040;
    localparam logic [13:0] SB_MDRIN  = 14'h0020;
    localparam logic [13:0] SB_MDROUT = 14'h0010;
    localparam logic [13:0] SB_IRIN   = 14'h0008;
    localparam logic [13:0] SB_YIN    = 14'h0004;
    localparam logic [13:0] SB_HIIN   = 14'h0002;
    localparam logic [13:0] SB_LOIN   = 14'h0001;
    localparam logic [3:0]  NO_ABORT  = 4'hF;

    typedef struct packed {
        logic [3:0]  st;
        logic [13:0] sb;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [3:0]  aop;
        logic        run;
    } exp_t;

    logic               clk = 1'b0;
    logic               clr;
    logic [31:0]        ir;
    logic               mem_rdy;
    logic               PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin;
    logic               Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
    logic [NREG-1:0]    rin;
    logic [NREG-1:0]    rout;
    logic [ALU_OPW-1:0] alu_op;
    logic               run;
    logic [3:0]         state_o;
    logic [13:0]        obs_sb;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q[$];

    logic [4:0] legal_ops [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                   5'b00111, 5'b01001, 5'b01010, 5'b01011,
                                   5'b01111, 5'b10000, 5'b10001, 5'b10010,
                                   5'b11010};

    ctrl_sequencer #(.NREG(NREG), .ALU_OPW(ALU_OPW)) dut (
        .clk      (clk),
        .clr      (clr),
        .ir       (ir),
        .mem_rdy  (mem_rdy),
        .PCout    (PCout),
        .MARin    (MARin),
        .IncPC    (IncPC),
        .Zin      (Zin),
        .Zlowout  (Zlowout),
        .Zhighout (Zhighout),
        .PCin     (PCin),
        .Read     (Read),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .IRin     (IRin),
        .Yin      (Yin),
        .HIin     (HIin),
        .LOin     (LOin),
        .rin      (rin),
        .rout     (rout),
        .alu_op   (alu_op),
        .run      (run),
        .state_o  (state_o)
    );

    assign obs_sb = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
                     Read, MDRin, MDRout, IRin, Yin, HIin, LOin};

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    function automatic exp_t mk(input logic [3:0] st, input logic [13:0] sb,
                                input logic [15:0] rin_v, input logic [15:0] rout_v,
                                input logic [3:0] aop, input logic run_v);
        exp_t e;
        e.st = st; e.sb = sb; e.rin = rin_v; e.rout = rout_v; e.aop = aop; e.run = run_v;
        return e;
    endfunction

    // 0 nop/unknown, 1 three-register ALU, 2 mul/div, 3 neg/not, 4 halt
    function automatic int model_kind(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01001, 5'b01010, 5'b01011: return 1;
            5'b01111, 5'b10000:                     return 2;
            5'b10001, 5'b10010:                     return 3;
            5'b11011:                               return 4;
            default:                                return 0;
        endcase
    endfunction

    function automatic logic [3:0] model_aop(input logic [4:0] op);
        case (op)
            5'b00011: return c_ALU_ADD;
            5'b00100: return c_ALU_SUB;
            5'b00101: return c_ALU_AND;
            5'b00110: return c_ALU_OR;
            5'b00111: return c_ALU_SHR;
            5'b01001: return c_ALU_SHL;
            5'b01010: return c_ALU_ROR;
            5'b01011: return c_ALU_ROL;
            5'b01111: return c_ALU_MUL;
            5'b10000: return c_ALU_DIV;
            5'b10001: return c_ALU_NEG;
            5'b10010: return c_ALU_NOT;
            default:  return 4'd0;
        endcase
    endfunction

    // Expand one instruction into its expected cycle-by-cycle outputs
    task automatic build(input logic [31:0] instr, input int waits);
        logic [4:0]  op;
        logic [15:0] ra, rb, rc;
        logic [3:0]  a;
        op = instr[31:27];
        ra = 16'd1 << instr[26:23];
        rb = 16'd1 << instr[22:19];
        rc = 16'd1 << instr[18:15];
        a  = model_aop(op);
        q.delete();
        q.push_back(mk(c_ST_T0, SB_PCOUT | SB_MARIN | SB_INCPC | SB_ZIN, 0, 0, c_ALU_INC, 1'b1));
        for (int j = 0; j <= waits; j++)
            q.push_back(mk(c_ST_T1, SB_ZLOW | SB_PCIN | SB_READ | SB_MDRIN, 0, 0, 0, 1'b1));
        q.push_back(mk(c_ST_T2, SB_MDROUT | SB_IRIN, 0, 0, 0, 1'b1));
        case (model_kind(op))
            1: begin
                q.push_back(mk(c_ST_T3, SB_YIN, 0, rb, 0, 1'b1));
                q.push_back(mk(c_ST_T4, SB_ZIN, 0, rc, a, 1'b1));
                q.push_back(mk(c_ST_T5, SB_ZLOW, ra, 0, 0, 1'b1));
            end
            2: begin
                q.push_back(mk(c_ST_T3, SB_YIN, 0, ra, 0, 1'b1));
                q.push_back(mk(c_ST_T4, SB_ZIN, 0, rb, a, 1'b1));
                q.push_back(mk(c_ST_T5, SB_ZLOW | SB_LOIN, 0, 0, 0, 1'b1));
                q.push_back(mk(c_ST_T6, SB_ZHIGH | SB_HIIN, 0, 0, 0, 1'b1));
            end
            3: begin
                q.push_back(mk(c_ST_T3, SB_ZIN, 0, rb, a, 1'b1));
                q.push_back(mk(c_ST_T4, SB_ZLOW, ra, 0, 0, 1'b1));
            end
            4: begin
                q.push_back(mk(c_ST_T3, 0, 0, 0, 0, 1'b1));
                q.push_back(mk(c_ST_HALT, 0, 0, 0, 0, 1'b0));
            end
            default: q.push_back(mk(c_ST_T3, 0, 0, 0, 0, 1'b1));
        endcase
    endtask

    task automatic check_cycle(input exp_t e, input string tag);
        chk({tag, ".state"}, 32'(state_o), 32'(e.st));
        chk({tag, ".strobes"}, 32'(obs_sb), 32'(e.sb));
        chk({tag, ".rin"}, 32'(rin), 32'(e.rin));
        chk({tag, ".rout"}, 32'(rout), 32'(e.rout));
        chk({tag, ".run"}, 32'(run), 32'(e.run));
        if ((e.sb & SB_ZIN) != 0) chk({tag, ".alu_op"}, 32'(alu_op), 32'(e.aop));
    endtask

    // Asynchronous clear between clock edges; outputs must drop immediately
    task automatic async_clear(input string tag);
        #1 clr = 1'b1;
        #1;
        chk({tag, ".clr_state"}, 32'(state_o), 32'(c_ST_RST));
        chk({tag, ".clr_strobes"}, 32'(obs_sb), 32'd0);
        chk({tag, ".clr_rin"}, 32'(rin), 32'd0);
        chk({tag, ".clr_rout"}, 32'(rout), 32'd0);
        chk({tag, ".clr_aop"}, 32'(alu_op), 32'd0);
        chk({tag, ".clr_run"}, 32'(run), 32'd1);
        #1 clr = 1'b0;
    endtask

    // Step one instruction; optionally clear asynchronously in a given state
    task automatic run_instr(input string name, input logic [31:0] instr,
                             input int waits, input logic [3:0] abort_st);
        int   t1_seen;
        exp_t e;
        t1_seen = 0;
        build(instr, waits);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            e = q[i];
            check_cycle(e, $sformatf("%s.c%0d", name, i));
            if (e.st == c_ST_T1) begin
                mem_rdy = (t1_seen == waits);
                t1_seen++;
            end else begin
                mem_rdy = 1'($urandom_range(0, 1));
            end
            if (e.st == c_ST_T2) ir = instr;
            if (e.st == abort_st) begin
                async_clear(name);
                return;
            end
        end
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] instr;
        clr     = 1'b1;
        mem_rdy = 1'b0;
        ir      = 32'd0;
        repeat (2) @(negedge clk);
        check_cycle(mk(c_ST_RST, 0, 0, 0, 0, 1'b1), "reset");
        chk("reset.alu_op", 32'(alu_op), 32'd0);
        clr = 1'b0;

        run_instr("and_r1_r2_r3", 32'h28918000, 0, NO_ABORT);
        run_instr("fetch_wait3", 32'h28918000, 3, NO_ABORT);
        run_instr("mul_r4_r5", 32'h7A280000, 0, NO_ABORT);
        run_instr("illegal", {5'b11111, 27'($urandom)}, 1, NO_ABORT);
        run_instr("clr_mid_t4", {5'b00011, 27'($urandom)}, 2, c_ST_T4);
        run_instr("after_clr", {5'b10001, 27'($urandom)}, 0, NO_ABORT);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                op = legal_ops[$urandom_range(0, 12)];
            end else begin
                op = 5'($urandom);
                if (op == 5'b11011) op = 5'b11111;
            end
            instr = {op, 27'($urandom)};
            run_instr($sformatf("rnd%0d_op%b", k, op), instr, $urandom_range(0, 3), NO_ABORT);
        end

        run_instr("halt", {5'b11011, 27'($urandom)}, 1, NO_ABORT);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            mem_rdy = 1'($urandom_range(0, 1));
            check_cycle(mk(c_ST_HALT, 0, 0, 0, 0, 1'b0), $sformatf("halt_hold%0d", k));
        end
        async_clear("halt_exit");
        run_instr("post_halt", {5'b00110, 27'($urandom)}, 2, NO_ABORT);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
